// File: rtl/mvd_pingpong_buf.sv
// Two-bank ping-pong store for per-PU motion-vector differences: the MC/MVD stage
// fills one bank while the entropy stage reads the previous LCU's bank.
module mvd_pingpong_buf #(
  parameter int unsigned MVD_WIDTH  = 11,
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    wr_en_i,
  input  logic [DEPTH_LOG2-1:0]   wr_addr_i,
  input  logic [2*MVD_WIDTH:0]    wr_data_i,
  input  logic                    rd_en_i,
  input  logic [DEPTH_LOG2-1:0]   rd_addr_i,
  output logic [2*MVD_WIDTH:0]    rd_data_o,
  output logic                    rd_hit_o,
  output logic                    rd_vld_o,
  output logic [DEPTH_LOG2:0]     rd_cnt_o,
  output logic                    wr_bank_o
);

  localparam int unsigned DW    = 2 * MVD_WIDTH + 1;
  localparam int unsigned DEPTH = 32'(1) << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned AW    = DEPTH_LOG2 + 1;

  logic [DW-1:0]      mem_q [2*DEPTH];
  logic [2*DEPTH-1:0] vld_q, vld_d;
  logic               wr_bank_q;
  logic [CW-1:0]      wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]      rd_cnt_q;
  logic [DW-1:0]      rd_data_q;
  logic               rd_hit_q;
  logic               rd_vld_q;

  logic [AW-1:0]      wr_idx;
  logic [AW-1:0]      rd_idx;
  logic               wr_new;

  // Bank select is the MSB of the flat index; reads always hit the other bank.
  assign wr_idx = {wr_bank_q, wr_addr_i};
  assign rd_idx = {~wr_bank_q, rd_addr_i};
  assign wr_new = wr_en_i && !vld_q[wr_idx];

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    vld_d    = vld_q;
    if (wr_new && (wr_cnt_q < CW'(DEPTH))) begin
      wr_cnt_d = wr_cnt_q + CW'(1);
    end
    if (wr_en_i) begin
      vld_d[wr_idx] = 1'b1;
    end
    // On a swap the current read bank becomes the write bank and starts empty.
    if (start_i) begin
      if (wr_bank_q) begin
        vld_d[DEPTH-1:0] = '0;
      end else begin
        vld_d[2*DEPTH-1:DEPTH] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      rd_data_q <= '0;
      rd_hit_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      rd_vld_q <= rd_en_i;
      if (start_i) begin
        wr_bank_q <= ~wr_bank_q;
        rd_cnt_q  <= wr_cnt_d;
        wr_cnt_q  <= '0;
      end else begin
        wr_cnt_q  <= wr_cnt_d;
      end
      if (rd_en_i) begin
        rd_hit_q  <= vld_q[rd_idx];
        rd_data_q <= vld_q[rd_idx] ? mem_q[rd_idx] : '0;
      end
    end
  end

  // Data array carries no reset; the valid bits mask stale contents.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx] <= wr_data_i;
    end
  end

  assign rd_data_o = rd_data_q;
  assign rd_hit_o  = rd_hit_q;
  assign rd_vld_o  = rd_vld_q;
  assign rd_cnt_o  = rd_cnt_q;
  assign wr_bank_o = wr_bank_q;

endmodule

// File: tb/tb_mvd_pingpong_buf.sv
// Scoreboard bench for mvd_pingpong_buf: a current-LCU / previous-LCU model
// predicts every read, the count and the bank index.
module tb_mvd_pingpong_buf;

  localparam int unsigned MW    = 11;
  localparam int unsigned AL    = 6;
  localparam int unsigned DW    = 2 * MW + 1;
  localparam int unsigned DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i, wr_en_i, rd_en_i;
  logic [AL-1:0] wr_addr_i, rd_addr_i;
  logic [DW-1:0] wr_data_i;
  logic [DW-1:0] rd_data_o;
  logic          rd_hit_o, rd_vld_o, wr_bank_o;
  logic [AL:0]   rd_cnt_o;

  mvd_pingpong_buf #(.MVD_WIDTH(MW), .DEPTH_LOG2(AL)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o), .rd_hit_o(rd_hit_o), .rd_vld_o(rd_vld_o),
    .rd_cnt_o(rd_cnt_o), .wr_bank_o(wr_bank_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          hit;
  } rd_exp_t;

  rd_exp_t       sb[$];
  logic [DW-1:0] cur_data  [DEPTH];
  logic [DW-1:0] prev_data [DEPTH];
  bit            cur_vld   [DEPTH];
  bit            prev_vld  [DEPTH];
  int            exp_cnt;
  bit            exp_bank;
  logic [DW-1:0] last_data;
  int            checks = 0;
  int            errors = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cur_vld[i]  = 1'b0;
      prev_vld[i] = 1'b0;
    end
    exp_cnt   = 0;
    exp_bank  = 1'b0;
    last_data = '0;
    sb.delete();
  endtask

  // Drive one cycle; the model advances at the same edge the DUT samples.
  task automatic step(input logic s, input logic we, input logic [AL-1:0] wa,
                      input logic [DW-1:0] wd, input logic re, input logic [AL-1:0] ra);
    rd_exp_t e;
    start_i = s; wr_en_i = we; wr_addr_i = wa; wr_data_i = wd;
    rd_en_i = re; rd_addr_i = ra;
    if (re) begin
      e.hit  = prev_vld[ra];
      e.data = prev_vld[ra] ? prev_data[ra] : '0;
      sb.push_back(e);
    end
    @(posedge clk);
    if (we) begin
      cur_data[wa] = wd;
      cur_vld[wa]  = 1'b1;
    end
    if (s) begin
      exp_cnt = 0;
      for (int i = 0; i < DEPTH; i++) begin
        if (cur_vld[i]) exp_cnt++;
        prev_vld[i]  = cur_vld[i];
        prev_data[i] = cur_data[i];
        cur_vld[i]   = 1'b0;
      end
      exp_bank = ~exp_bank;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents read data.
  always @(negedge clk) begin
    rd_exp_t e;
    check("rd_cnt", 32'(rd_cnt_o), 32'(exp_cnt));
    check("wr_bank", 32'(wr_bank_o), 32'(exp_bank));
    if (rd_vld_o) begin
      if (sb.size() == 0) begin
        check("unexpected_rd_vld", 32'(rd_vld_o), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rd_data", 32'(rd_data_o), 32'(e.data));
        check("rd_hit", 32'(rd_hit_o), 32'(e.hit));
        last_data = e.data;
      end
    end else begin
      check("rd_data_hold", 32'(rd_data_o), 32'(last_data));
    end
  end

  initial begin
    rst = 1'b1;
    start_i = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0;
    wr_addr_i = '0; rd_addr_i = '0; wr_data_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_vld", 32'(rd_vld_o), 32'd0);
    check("reset_data", 32'(rd_data_o), 32'd0);
    check("reset_hit", 32'(rd_hit_o), 32'd0);
    check("reset_cnt", 32'(rd_cnt_o), 32'd0);
    check("reset_bank", 32'(wr_bank_o), 32'd0);
    rst = 1'b0;
    idle();

    // Full fill then read back
    for (int a = 0; a < DEPTH; a++) step(1'b0, 1'b1, AL'(a), DW'(a), 1'b0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    check("fill_cnt", 32'(rd_cnt_o), 32'd64);
    check("fill_bank", 32'(wr_bank_o), 32'd1);
    for (int a = 0; a < DEPTH; a++) step(1'b0, 1'b0, '0, '0, 1'b1, AL'(a));
    idle();

    // Rewrite of one address, then hit and miss
    step(1'b0, 1'b1, AL'(5), DW'(32'h12345), 1'b0, '0);
    step(1'b0, 1'b1, AL'(5), DW'(32'h00ABC), 1'b0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    check("sparse_cnt", 32'(rd_cnt_o), 32'd1);
    step(1'b0, 1'b0, '0, '0, 1'b1, AL'(5));
    step(1'b0, 1'b0, '0, '0, 1'b1, AL'(6));
    idle();

    // Write in the same cycle as the swap
    step(1'b1, 1'b1, AL'(9), DW'(7), 1'b0, '0);
    check("coinc_cnt", 32'(rd_cnt_o), 32'd1);
    step(1'b0, 1'b0, '0, '0, 1'b1, AL'(9));
    idle();

    // Random concurrent traffic with occasional back-to-back swaps
    for (int lcu = 0; lcu < 10; lcu++) begin
      int n;
      n = int'($urandom_range(5, 70));
      for (int k = 0; k < n; k++)
        step(1'b0, 1'($urandom), AL'($urandom), DW'($urandom), 1'($urandom), AL'($urandom));
      step(1'b1, 1'($urandom), AL'($urandom), DW'($urandom), 1'($urandom), AL'($urandom));
      if (lcu % 3 == 0)
        step(1'b1, 1'b0, '0, '0, 1'($urandom), AL'($urandom));
    end
    idle();

    // Entry written two LCUs ago must read as stale
    step(1'b0, 1'b1, AL'(20), DW'(32'h55), 1'b0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    check("b2b_cnt", 32'(rd_cnt_o), 32'd0);
    step(1'b0, 1'b0, '0, '0, 1'b1, AL'(20));
    idle();

    // Asynchronous reset in the middle of a fill
    for (int a = 0; a < 10; a++) step(1'b0, 1'b1, AL'(a), DW'(a + 100), 1'b1, AL'(a));
    #2 rst = 1'b1;
    #1;
    check("async_rst_vld", 32'(rd_vld_o), 32'd0);
    check("async_rst_data", 32'(rd_data_o), 32'd0);
    check("async_rst_cnt", 32'(rd_cnt_o), 32'd0);
    check("async_rst_bank", 32'(wr_bank_o), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    check("post_rst_cnt", 32'(rd_cnt_o), 32'd0);
    check("post_rst_bank", 32'(wr_bank_o), 32'd1);
    step(1'b0, 1'b0, '0, '0, 1'b1, AL'(0));
    idle();
    idle();

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
